// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Optional build macro: SSD_LZ_SUPPRESS_EN (leading-zero suppression).
package ssd_pkg;

   localparam int DEF_DIGIT_COUNT  = 4;
   localparam int DEF_REFRESH_DIV  = 100000;
   localparam int DEF_BLANK_CYCLES = 1000;

   localparam logic AN_ON  = 1'b0;
   localparam logic AN_OFF = 1'b1;
   localparam logic DP_ON  = 1'b0;
   localparam logic DP_OFF = 1'b1;

   function automatic int cnt_width(input int div);
      return $clog2(div);
   endfunction

endpackage

// File: rtl/ssd_refresh_timer.sv
// Per-digit slot counter: flags the last cycle of a slot and the
// anti-ghosting blank window at the start of each slot.
module ssd_refresh_timer
   import ssd_pkg::*;
#(
   parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic slot_end,
   output logic blank_phase
);

   localparam int CW = cnt_width(REFRESH_DIV);
   localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] cnt;

   // slot counter; held at zero while scanning is disabled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (!en)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign slot_end = en && (cnt == LAST);

   if (BLANK_CYCLES == 0) begin : g_noblank
      assign blank_phase = 1'b0;
   end else begin : g_blank
      localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);
      assign blank_phase = (cnt < BLANK);
   end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed common-anode 7-seg scan driver with frame-synchronous
// shadow update. Optional macro: SSD_LZ_SUPPRESS_EN.
module ssd_scan_driver
   import ssd_pkg::*;
#(
   parameter int DIGIT_COUNT  = DEF_DIGIT_COUNT,
   parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     update,
   input  logic [4*DIGIT_COUNT-1:0] value_in,
   input  logic [DIGIT_COUNT-1:0]   dp_in,
   output logic [3:0]               digit,
   output logic [DIGIT_COUNT-1:0]   an,
   output logic                     dp,
   output logic                     frame_done
);

   localparam int IW = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;
   localparam logic [IW-1:0] LASTI = IW'(DIGIT_COUNT - 1);

   logic                     slot_end;
   logic                     blank_phase;
   logic                     boundary;
   logic                     run;
   logic                     pending;
   logic                     show;
   logic [IW-1:0]            idx;
   logic [4*DIGIT_COUNT-1:0] shadow_val;
   logic [DIGIT_COUNT-1:0]   shadow_dp;
   logic [4*DIGIT_COUNT-1:0] act_val;
   logic [DIGIT_COUNT-1:0]   act_dp;

   ssd_refresh_timer #(
      .REFRESH_DIV  (REFRESH_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .slot_end    (slot_end),
      .blank_phase (blank_phase)
   );

   assign boundary = slot_end && (idx == LASTI);

   // digit index, registered enable and frame pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx        <= '0;
         run        <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         run        <= en;
         frame_done <= boundary;
         if (!en)
            idx <= '0;
         else if (boundary)
            idx <= '0;
         else if (slot_end)
            idx <= idx + 1'b1;
      end
   end

   // shadow capture and frame-synchronous transfer to active
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_val <= '0;
         shadow_dp  <= '0;
         pending    <= 1'b0;
         act_val    <= '0;
         act_dp     <= '0;
      end else begin
         if (update) begin
            shadow_val <= value_in;
            shadow_dp  <= dp_in;
         end
         if (boundary) begin
            pending <= 1'b0;
            if (update) begin
               act_val <= value_in;
               act_dp  <= dp_in;
            end else if (pending) begin
               act_val <= shadow_val;
               act_dp  <= shadow_dp;
            end
         end else if (update) begin
            pending <= 1'b1;
         end
      end
   end

`ifdef SSD_LZ_SUPPRESS_EN
   logic [DIGIT_COUNT-1:0] lit_mask;

   // a digit is lit if it or any more significant digit carries content
   always_comb begin
      logic nz;
      nz       = 1'b0;
      lit_mask = '0;
      for (int k = DIGIT_COUNT - 1; k >= 0; k--) begin
         nz          = nz | (|act_val[4*k +: 4]) | act_dp[k];
         lit_mask[k] = nz || (k == 0);
      end
   end

   assign show = lit_mask[idx];
`else
   assign show = 1'b1;
`endif

   // output decode from registered state only
   always_comb begin
      digit = act_val[{idx, 2'b00} +: 4];
      dp    = act_dp[idx] ? DP_ON : DP_OFF;
      an    = {DIGIT_COUNT{AN_OFF}};
      if (run && !blank_phase && show)
         an[idx] = AN_ON;
   end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver (4 digits, 4-cycle slots,
// 1 blank cycle); honours SSD_LZ_SUPPRESS_EN when defined.
module tb_ssd_scan_driver;

   typedef struct {
      logic [3:0] an;
      logic [3:0] digit;
      logic       dp;
      logic       fd;
   } exp_t;

   bit          clk = 1'b0;
   logic        rst;
   logic        en;
   logic        update;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic [3:0]  digit;
   logic [3:0]  an;
   logic        dp;
   logic        frame_done;

   exp_t        q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          ph       = 0;
   logic [15:0] exp_act  = '0;
   logic [3:0]  exp_dp   = '0;

   ssd_scan_driver #(
      .DIGIT_COUNT  (4),
      .REFRESH_DIV  (4),
      .BLANK_CYCLES (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .update     (update),
      .value_in   (value_in),
      .dp_in      (dp_in),
      .digit      (digit),
      .an         (an),
      .dp         (dp),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input bit ok,
                        input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (ok)
         n_pass++;
      else
         $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   function automatic bit shown(input int ix);
`ifdef SSD_LZ_SUPPRESS_EN
      logic [15:0] v;
      logic [3:0]  d;
      v = exp_act >> (4 * ix);
      d = exp_dp >> ix;
      return (ix == 0) || (v != 0) || (d != 0);
`else
      return (ix >= 0);
`endif
   endfunction

   // push the outputs expected after the next edge, then take that edge
   task automatic step();
      exp_t e;
      int   nph;
      bit   enq;
      int   ix;
      if (rst && en) begin
         nph = (ph + 1) % 16;
         enq = 1'b1;
      end else begin
         nph = 0;
         enq = 1'b0;
      end
      ix      = nph / 4;
      e.digit = exp_act[ix*4 +: 4];
      e.dp    = ~exp_dp[ix];
      e.an    = 4'hF;
      if (enq && (nph % 4 != 0) && shown(ix))
         e.an[ix] = 1'b0;
      e.fd = rst && en && (ph == 15);
      q.push_back(e);
      @(posedge clk);
      #1;
      ph     = nph;
      update = 1'b0;
   endtask

   task automatic run_until(input int t);
      int guard = 0;
      while (ph != t && guard < 40) begin
         step();
         guard++;
      end
      check("run_until", ph == t, 16'(ph), 16'(t));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++)
         step();
   endtask

   // monitor: compare the DUT against the oldest expectation each cycle
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("outputs",
               an === e.an && digit === e.digit &&
               dp === e.dp && frame_done === e.fd,
               {an, digit, 2'b00, dp, frame_done, 4'h0},
               {e.an, e.digit, 2'b00, e.dp, e.fd, 4'h0});
      end
   end

   initial begin
      rst      = 1'b0;
      en       = 1'b1;
      update   = 1'b0;
      value_in = '0;
      dp_in    = '0;
      #1;

      // 1: reset then free-running scan of zeros
      steps(3);
      rst = 1'b1;
      steps(20);

      // 2: mid-frame update waits for the wrap
      run_until(5);
      value_in = 16'h1234;
      dp_in    = 4'b0100;
      update   = 1'b1;
      step();
      run_until(15);
      exp_act = 16'h1234;
      exp_dp  = 4'b0100;
      step();
      steps(16);

      // 3: update on the boundary cycle bypasses to active
      run_until(15);
      value_in = 16'hABCD;
      dp_in    = 4'b0000;
      update   = 1'b1;
      exp_act  = 16'hABCD;
      exp_dp   = 4'b0000;
      step();
      check("pending_clear", dut.pending == 1'b0,
            16'(dut.pending), 16'h0);
      steps(16);

      // 4: two updates in one frame, the last wins
      run_until(2);
      value_in = 16'h1111;
      update   = 1'b1;
      step();
      steps(3);
      value_in = 16'h2222;
      update   = 1'b1;
      step();
      run_until(15);
      exp_act = 16'h2222;
      step();
      steps(8);

      // 5: enable dropped mid-slot, then restart from digit 0
      run_until(6);
      en = 1'b0;
      steps(3);
      en = 1'b1;
      steps(18);

      // 6: leading-zero patterns
      run_until(15);
      value_in = 16'h0050;
      update   = 1'b1;
      exp_act  = 16'h0050;
      step();
      steps(16);
      run_until(15);
      value_in = 16'h0000;
      update   = 1'b1;
      exp_act  = 16'h0000;
      step();
      steps(16);

      // 7: asynchronous reset mid-slot
      run_until(15);
      value_in = 16'h9876;
      update   = 1'b1;
      exp_act  = 16'h9876;
      step();
      steps(5);
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("async_an", an === 4'hF, 16'(an), 16'hF);
      check("async_digit", digit === 4'h0, 16'(digit), 16'h0);
      check("async_dp", dp === 1'b1, 16'(dp), 16'h1);
      exp_act = '0;
      exp_dp  = '0;
      steps(2);
      rst = 1'b1;
      steps(8);

      begin
         int guard = 0;
         while (q.size() > 0 && guard < 10) begin
            @(negedge clk);
            #1;
            guard++;
         end
         check("drain", q.size() == 0, 16'(q.size()), 16'h0);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
